// File: rtl/apb_timer_pkg.sv
// Shared constants for the APB multi-channel timer: register offsets, CTRL bit
// positions and the APB phase-tracking state encoding.
package apb_timer_pkg;

    localparam int unsigned OFF_CTRL    = 32'h0;
    localparam int unsigned OFF_LOAD    = 32'h4;
    localparam int unsigned OFF_COUNT   = 32'h8;
    localparam int unsigned OFF_STATUS  = 32'h80;
    localparam int unsigned CHAN_STRIDE = 32'h10;

    localparam int unsigned CTRL_START  = 0;
    localparam int unsigned CTRL_IE     = 1;
    localparam int unsigned CTRL_RELOAD = 2;
    localparam int unsigned CTRL_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_timer_n_if.sv
// APB slave bus bundle for the timer; the bench drives the master modport.
interface apb_timer_n_if #(
    parameter int unsigned AW = 8
);
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_timer_chan.sv
// One timer channel: CTRL/LOAD/COUNT registers, terminal-hit detection and the
// sticky pending flag.
module apb_timer_chan
    import apb_timer_pkg::*;
#(
    parameter int unsigned CW = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ctrl_we_i,
    input  logic              load_we_i,
    input  logic              pend_clr_i,
    input  logic [CTRL_W-1:0] ctrl_wdata_i,
    input  logic [CW-1:0]     load_wdata_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CW-1:0]     load_o,
    output logic [CW-1:0]     count_o,
    output logic              pend_o
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CW-1:0]     load_q, load_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pend_q, pend_d;
    logic              hit_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            pend_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            load_q  <= load_d;
            count_q <= count_d;
            pend_q  <= pend_d;
        end
    end

    // Hit beats a same-cycle clear; a CTRL write overrides counter/START updates.
    always_comb begin
        ctrl_d  = ctrl_q;
        load_d  = load_q;
        count_d = count_q;
        pend_d  = pend_q;
        hit_c   = ctrl_q[CTRL_START] && (count_q == load_q);

        if (hit_c) begin
            count_d = '0;
            pend_d  = 1'b1;
            if (!ctrl_q[CTRL_RELOAD]) begin
                ctrl_d[CTRL_START] = 1'b0;
            end
        end else begin
            if (ctrl_q[CTRL_START]) begin
                count_d = count_q + CW'(1);
            end
            if (pend_clr_i) begin
                pend_d = 1'b0;
            end
        end

        if (ctrl_we_i) begin
            ctrl_d  = ctrl_wdata_i;
            count_d = ctrl_wdata_i[CTRL_START] ? '0 : count_q;
        end
        if (load_we_i) begin
            load_d = load_wdata_i;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign load_o  = load_q;
    assign count_o = count_q;
    assign pend_o  = pend_q;

endmodule

// File: rtl/apb_timer_n.sv
// APB timer block with NCH channels: address decode, phase tracking, read mux
// and the combined active-low interrupt.
module apb_timer_n
    import apb_timer_pkg::*;
#(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 32,
    parameter int unsigned AW  = 8
) (
    input  logic          SYSCLK,
    input  logic          RST_B,
    apb_timer_n_if.slave  apb,
    output logic          INT_B
);

    localparam int unsigned IW = AW - 4;
    localparam logic [AW-3:0] STATUS_WORD = (AW-2)'(OFF_STATUS >> 2);
    localparam logic [1:0]    SEL_CTRL    = 2'(OFF_CTRL >> 2);
    localparam logic [1:0]    SEL_LOAD    = 2'(OFF_LOAD >> 2);
    localparam logic [1:0]    SEL_COUNT   = 2'(OFF_COUNT >> 2);
    localparam logic [1:0]    SEL_NONE    = 2'd3;

    apb_state_e state_q, state_d;

    logic [IW-1:0]     ch_idx;
    logic [1:0]        reg_sel;
    logic              is_status, ch_valid, err_c, access_c, wr_ok_c, rd_ok_c;
    logic [31:0]       rdata_c;
    logic [CTRL_W-1:0] ctrl_a  [NCH];
    logic [CW-1:0]     load_a  [NCH];
    logic [CW-1:0]     count_a [NCH];
    logic [NCH-1:0]    pend, ie;
    logic              unused_bits;

    always_ff @(posedge SYSCLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (apb.PSEL && !apb.PENABLE) state_d = ST_SETUP;
            ST_SETUP:  state_d = (apb.PSEL && apb.PENABLE) ? ST_ACCESS : ST_IDLE;
            ST_ACCESS: state_d = (apb.PSEL && !apb.PENABLE) ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Decode: channel blocks are 16 bytes apart, STATUS sits after the last block.
    assign ch_idx    = apb.PADDR[AW-1:4];
    assign reg_sel   = apb.PADDR[3:2];
    assign is_status = (apb.PADDR[AW-1:2] == STATUS_WORD);
    assign ch_valid  = (32'(ch_idx) < NCH) && (reg_sel != SEL_NONE);
    assign err_c     = !(is_status || ch_valid) ||
                       (apb.PWRITE && !is_status && (reg_sel == SEL_COUNT));
    assign access_c  = apb.PSEL && apb.PENABLE;
    assign wr_ok_c   = access_c && apb.PWRITE && !err_c;
    assign rd_ok_c   = access_c && !apb.PWRITE && !err_c;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic hit_ch;
        assign hit_ch = wr_ok_c && !is_status && (ch_idx == IW'(c));

        apb_timer_chan #(.CW(CW)) u_chan (
            .clk          (SYSCLK),
            .rst_n        (RST_B),
            .ctrl_we_i    (hit_ch && (reg_sel == SEL_CTRL)),
            .load_we_i    (hit_ch && (reg_sel == SEL_LOAD)),
            .pend_clr_i   (wr_ok_c && is_status && apb.PWDATA[c]),
            .ctrl_wdata_i (apb.PWDATA[CTRL_W-1:0]),
            .load_wdata_i (apb.PWDATA[CW-1:0]),
            .ctrl_o       (ctrl_a[c]),
            .load_o       (load_a[c]),
            .count_o      (count_a[c]),
            .pend_o       (pend[c])
        );

        assign ie[c] = ctrl_a[c][CTRL_IE];
    end

    always_comb begin
        rdata_c = '0;
        if (is_status) begin
            rdata_c = 32'(pend);
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (ch_idx == IW'(c)) begin
                    case (reg_sel)
                        SEL_CTRL:  rdata_c = 32'(ctrl_a[c]);
                        SEL_LOAD:  rdata_c = 32'(load_a[c]);
                        SEL_COUNT: rdata_c = 32'(count_a[c]);
                        default:   rdata_c = '0;
                    endcase
                end
            end
        end
    end

    assign apb.PRDATA  = rd_ok_c ? rdata_c : '0;
    assign apb.PSLVERR = access_c && err_c;
    assign apb.PREADY  = 1'b1;
    assign INT_B       = ~|(pend & ie);

    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

endmodule

// File: tb/tb_apb_timer_n.sv
// Randomised and directed bench for apb_timer_n with a scoreboard fed by a
// cycle-level reference model of the register map and timer rules.
module tb_apb_timer_n;

    localparam int unsigned NCH   = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned CMASK = (32'(1) << CW) - 1;

    typedef struct {
        string       name;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    logic SYSCLK = 1'b0;
    logic RST_B;
    logic INT_B;

    apb_timer_n_if #(.AW(AW)) bus ();

    apb_timer_n #(.NCH(NCH), .CW(CW), .AW(AW)) dut (
        .SYSCLK (SYSCLK),
        .RST_B  (RST_B),
        .apb    (bus.slave),
        .INT_B  (INT_B)
    );

    always #5 SYSCLK = ~SYSCLK;

    int unsigned    m_ctrl  [NCH];
    int unsigned    m_load  [NCH];
    int unsigned    m_count [NCH];
    bit [NCH-1:0]   m_pend;
    exp_t           sb_q[$];
    exp_t           mon_e;
    int             n_pass = 0;
    int             n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_note(input string name);
        n_total++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Register-map rules: word address in, error / read value out.
    function automatic bit m_err(input bit wr, input int unsigned a);
        int unsigned c, off;
        if (a == 32'h80) return 1'b0;
        if (a > 32'h80) return 1'b1;
        c   = a / 16;
        off = a % 16;
        if (c >= NCH || off == 12) return 1'b1;
        return wr && (off == 8);
    endfunction

    function automatic logic [31:0] m_read(input int unsigned a);
        int unsigned c, off;
        if (a == 32'h80) return 32'(m_pend);
        c   = a / 16;
        off = a % 16;
        if (off == 0) return m_ctrl[c];
        if (off == 4) return m_load[c];
        return m_count[c];
    endfunction

    function automatic logic m_int_b();
        for (int c = 0; c < NCH; c++)
            if (m_pend[c] && (m_ctrl[c] & 2) != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Reference timer: each enabled channel counts, fires at COUNT==LOAD, then
    // applies any committed APB write.
    always @(posedge SYSCLK or negedge RST_B) begin : model
        int unsigned a, ctl, cnt, wc, wo;
        bit commit, fired, to_stat;
        if (!RST_B) begin
            for (int c = 0; c < NCH; c++) begin
                m_ctrl[c]  <= 0;
                m_load[c]  <= 0;
                m_count[c] <= 0;
            end
            m_pend <= '0;
        end else begin
            a       = 32'(bus.PADDR) & 32'hFC;
            commit  = bus.PSEL && bus.PENABLE && bus.PWRITE && !m_err(1'b1, a);
            to_stat = (a == 32'h80);
            wc      = a / 16;
            wo      = a % 16;
            for (int c = 0; c < NCH; c++) begin
                ctl   = m_ctrl[c];
                cnt   = m_count[c];
                fired = ((ctl & 1) != 0) && (cnt == m_load[c]);
                if (fired) begin
                    m_pend[c] <= 1'b1;
                    cnt = 0;
                    if ((ctl & 4) == 0) ctl = ctl & ~32'd1;
                end else begin
                    if ((ctl & 1) != 0) cnt = (cnt + 1) & CMASK;
                    if (commit && to_stat && bus.PWDATA[c]) m_pend[c] <= 1'b0;
                end
                if (commit && !to_stat && wc == 32'(c)) begin
                    if (wo == 0) begin
                        ctl = bus.PWDATA & 32'h7;
                        cnt = ((ctl & 1) != 0) ? 0 : m_count[c];
                    end else if (wo == 4) begin
                        m_load[c] <= bus.PWDATA & CMASK;
                    end
                end
                m_ctrl[c]  <= ctl;
                m_count[c] <= cnt;
            end
        end
    end

    // Monitor: interrupt every cycle, and one scoreboard entry per access phase.
    always @(negedge SYSCLK) begin
        if (RST_B === 1'b1) begin
            check("int_b", 32'(INT_B), 32'(m_int_b()));
            if (bus.PSEL && bus.PENABLE) begin
                check("pready", 32'(bus.PREADY), 32'd1);
                if (sb_q.size() == 0) begin
                    fail_note("scoreboard_underflow");
                end else begin
                    mon_e = sb_q.pop_front();
                    check({mon_e.name, "_pslverr"}, 32'(bus.PSLVERR), 32'(mon_e.err));
                    check({mon_e.name, "_prdata"}, bus.PRDATA, mon_e.rdata);
                end
            end
        end
    end

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic xfer(input bit wr, input int unsigned addr, input logic [31:0] data,
                        input string name, input bit use_c, input bit c_err,
                        input logic [31:0] c_rd);
        exp_t e;
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = wr;
        bus.PADDR   = AW'(addr);
        bus.PWDATA  = data;
        @(posedge SYSCLK); #1;
        bus.PENABLE = 1'b1;
        e.name = name;
        if (use_c) begin
            e.err   = c_err;
            e.rdata = c_rd;
        end else begin
            e.err   = m_err(wr, addr & 32'hFC);
            e.rdata = (wr || e.err) ? 32'd0 : m_read(addr & 32'hFC);
        end
        sb_q.push_back(e);
        @(posedge SYSCLK); #1;
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
    endtask

    task automatic wr(input int unsigned addr, input logic [31:0] data);
        xfer(1'b1, addr, data, "wr", 1'b0, 1'b0, 32'd0);
    endtask

    task automatic rd(input int unsigned addr, input string name);
        xfer(1'b0, addr, 32'd0, name, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic rd_c(input int unsigned addr, input string name, input logic [31:0] v);
        xfer(1'b0, addr, 32'd0, name, 1'b1, 1'b0, v);
    endtask

    task automatic acc_err(input bit w, input int unsigned addr, input string name);
        xfer(w, addr, 32'h12, name, 1'b1, 1'b1, 32'd0);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge SYSCLK);
        #1;
    endtask

    task automatic wait_count(input int ch, input int unsigned val, input string name);
        for (int i = 0; i < 400; i++) begin
            if (m_count[ch] == val) return;
            @(posedge SYSCLK); #1;
        end
        fail_note(name);
    endtask

    task automatic do_reset();
        RST_B = 1'b0;
        cycles(2);
        RST_B = 1'b1;
    endtask

    initial begin
        int unsigned sel, c, off, addr;
        logic [31:0] data;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        bus.PADDR = '0;  bus.PWDATA = '0;
        RST_B = 1'b1;
        #2 RST_B = 1'b0;
        #1;
        check("rst_int_b", 32'(INT_B), 32'd1);
        check("rst_prdata", bus.PRDATA, 32'd0);
        check("rst_pslverr", 32'(bus.PSLVERR), 32'd0);
        check("rst_pready", 32'(bus.PREADY), 32'd1);
        cycles(3);
        RST_B = 1'b1;
        rd_c(32'h00, "rst_ctrl0", 32'd0);
        rd_c(32'h34, "rst_load3", 32'd0);
        rd_c(32'h28, "rst_count2", 32'd0);
        rd_c(32'h80, "rst_status", 32'd0);

        // Periodic channel 0, LOAD=5.
        wr(32'h04, 32'd5);
        wr(32'h00, 32'h7);
        for (int i = 0; i < 12; i++) rd(32'h08, "periodic_count0");
        rd_c(32'h80, "periodic_status", 32'h1);
        rd_c(32'h00, "periodic_ctrl0", 32'h7);

        // STATUS clear landing on the first hit of channel 0.
        do_reset();
        wr(32'h04, 32'd5);
        wr(32'h00, 32'h7);
        wait_count(0, 4, "wait_hit_cycle");
        wr(32'h80, 32'h1);
        rd_c(32'h80, "w1c_vs_hit", 32'h1);
        wr(32'h00, 32'h0);
        wr(32'h80, 32'h1);
        rd_c(32'h80, "w1c_clear", 32'h0);

        // One-shot channel 1.
        do_reset();
        wr(32'h14, 32'd2);
        wr(32'h10, 32'h3);
        cycles(6);
        rd_c(32'h10, "oneshot_ctrl1", 32'h2);
        rd_c(32'h18, "oneshot_count1", 32'd0);
        rd_c(32'h80, "oneshot_status", 32'h2);
        check("oneshot_int_low", 32'(INT_B), 32'd0);
        cycles(10);
        rd_c(32'h80, "oneshot_single", 32'h2);
        wr(32'h80, 32'h2);
        check("oneshot_int_high", 32'(INT_B), 32'd1);

        // Error responses change nothing.
        acc_err(1'b1, 32'h18, "err_wr_count");
        acc_err(1'b0, 32'h40, "err_rd_ch4");
        acc_err(1'b0, 32'h84, "err_rd_84");
        acc_err(1'b0, 32'h1C, "err_rd_rsvd");
        acc_err(1'b1, 32'h54, "err_wr_ch5");
        rd_c(32'h18, "err_count1_kept", 32'd0);
        rd_c(32'h14, "err_load1_kept", 32'd2);

        // Reset during an access-phase write while channels run.
        do_reset();
        wr(32'h04, 32'd1);
        wr(32'h00, 32'h7);
        wr(32'h30, 32'h5);
        cycles(5);
        check("pre_rst_int_low", 32'(INT_B), 32'd0);
        bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 8'h24; bus.PWDATA = 32'h55;
        @(posedge SYSCLK); #1;
        bus.PENABLE = 1'b1;
        #2 RST_B = 1'b0;
        #1;
        check("midrst_int_b", 32'(INT_B), 32'd1);
        check("midrst_prdata", bus.PRDATA, 32'd0);
        check("midrst_pslverr", 32'(bus.PSLVERR), 32'd0);
        check("midrst_pready", 32'(bus.PREADY), 32'd1);
        @(posedge SYSCLK); #1;
        bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
        cycles(2);
        RST_B = 1'b1;
        rd_c(32'h24, "midrst_load2", 32'd0);
        rd_c(32'h00, "midrst_ctrl0", 32'd0);
        rd_c(32'h08, "midrst_count0", 32'd0);
        rd_c(32'h38, "midrst_count3", 32'd0);
        rd_c(32'h80, "midrst_status", 32'd0);

        // LOAD lowered below COUNT: wraps through 0xFF before hitting.
        wr(32'h04, 32'hFF);
        wr(32'h00, 32'h1);
        wait_count(0, 32'h0E, "wait_count_0e");
        wr(32'h04, 32'h3);
        rd_c(32'h80, "wrap_no_early_hit", 32'd0);
        rd(32'h08, "wrap_count0");
        cycles(100);
        rd_c(32'h80, "wrap_not_yet", 32'd0);
        cycles(160);
        rd_c(32'h80, "wrap_hit", 32'h1);
        rd_c(32'h00, "wrap_oneshot_ctrl", 32'h0);
        rd_c(32'h08, "wrap_count_zero", 32'd0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cycles($urandom_range(0, 2));
            sel = $urandom_range(0, 19);
            if (sel < 16) begin
                c    = $urandom_range(0, NCH);
                off  = $urandom_range(0, 3) * 4;
                addr = c * 16 + off;
            end else if (sel < 19) begin
                off  = 0;
                addr = 32'h80;
            end else begin
                off  = 0;
                addr = 32'h80 + 4 * $urandom_range(1, 3);
            end
            data = $urandom;
            if (off == 4 && $urandom_range(0, 3) != 0) data = $urandom_range(0, 12);
            xfer(1'($urandom_range(0, 1)), addr, data, "rnd", 1'b0, 1'b0, 32'd0);
        end

        cycles(2);
        if (sb_q.size() != 0) fail_note("scoreboard_leftover");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
